// File: rtl/tc0480scp_rom_responder_if.sv
// Bundles the TC0480SCP ROM fetch port and the SDRAM read channel; both
// sides use toggle handshakes. slave = the responder, master = its environment.
interface tc0480scp_rom_responder_if #(
  parameter int unsigned SDR_AW = 27
) ();
  logic [20:0]       rom_address;
  logic              rom_req;
  logic              rom_ack;
  logic [63:0]       rom_data;
  logic [SDR_AW-1:0] sdr_addr;
  logic              sdr_req;
  logic              sdr_ack;
  logic [15:0]       sdr_data;

  modport slave (
    input  rom_address, rom_req, sdr_ack, sdr_data,
    output rom_ack, rom_data, sdr_addr, sdr_req
  );

  modport master (
    output rom_address, rom_req, sdr_ack, sdr_data,
    input  rom_ack, rom_data, sdr_addr, sdr_req
  );
endinterface

// File: rtl/tc0480scp_rom_responder.sv
// Turns each 64-bit TC0480SCP ROM fetch into four 16-bit SDRAM reads.
// Define ROM_LAST_HIT_EN to answer repeats of the last granule without SDRAM access.
module tc0480scp_rom_responder #(
  parameter int unsigned       SDR_AW   = 27,
  parameter logic [SDR_AW-1:0] ROM_BASE = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  tc0480scp_rom_responder_if.slave    bus,
  input  logic                        flush,
  output logic                        busy
);

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t            r_state;
  logic [1:0]        r_beat;
  logic [2:0][15:0]  r_stage;
  logic              r_rom_ack;
  logic [63:0]       r_rom_data;
  logic              r_sdr_req;
  logic [SDR_AW-1:0] r_sdr_addr;
  logic              r_busy;

  logic [20:0]       w_addr;
  logic [SDR_AW-1:0] w_start_addr;
  logic              w_pending;
  logic              w_beat_done;
  logic              w_hit;
  logic              w_unused;

  assign w_addr       = {bus.rom_address[20:3], 3'b000};
  assign w_start_addr = ROM_BASE + SDR_AW'(w_addr);
  assign w_pending    = bus.rom_req != r_rom_ack;
  assign w_beat_done  = bus.sdr_ack == r_sdr_req;

`ifdef ROM_LAST_HIT_EN
  logic [17:0] r_tag;
  logic [17:0] r_fetch_tag;
  logic        r_valid;

  // flush on the detection edge forces the normal fetch path
  assign w_hit    = r_valid && !flush && (bus.rom_address[20:3] == r_tag);
  assign w_unused = ^bus.rom_address[2:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag       <= '0;
      r_fetch_tag <= '0;
      r_valid     <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_pending && !w_hit)
        r_fetch_tag <= bus.rom_address[20:3];
      if (r_state == S_FETCH && w_beat_done && r_beat == 2'd3) begin
        r_tag   <= r_fetch_tag;
        r_valid <= 1'b1;
      end
      if (flush)
        r_valid <= 1'b0;
    end
  end
`else
  assign w_hit    = 1'b0;
  assign w_unused = ^{bus.rom_address[2:0], flush};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_stage    <= '0;
      r_rom_ack  <= 1'b0;
      r_rom_data <= '0;
      r_sdr_req  <= 1'b0;
      r_sdr_addr <= '0;
      r_busy     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pending && w_hit) begin
            r_rom_ack <= ~r_rom_ack;
          end else if (w_pending) begin
            r_sdr_addr <= w_start_addr;
            r_sdr_req  <= ~r_sdr_req;
            r_beat     <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_beat_done) begin
            // rom_data only moves on the final beat; earlier words go to staging
            if (r_beat == 2'd3) begin
              r_rom_data <= {bus.sdr_data, r_stage[2], r_stage[1], r_stage[0]};
              r_rom_ack  <= ~r_rom_ack;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_stage[r_beat] <= bus.sdr_data;
              r_beat          <= r_beat + 2'd1;
              r_sdr_addr      <= r_sdr_addr + SDR_AW'(2);
              r_sdr_req       <= ~r_sdr_req;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_ack  = r_rom_ack;
  assign bus.rom_data = r_rom_data;
  assign bus.sdr_req  = r_sdr_req;
  assign bus.sdr_addr = r_sdr_addr;
  assign busy         = r_busy;

endmodule

// File: tb/tb_tc0480scp_rom_responder.sv
// Directed bench for tc0480scp_rom_responder with a toggle-handshake SDRAM
// model returning the low 16 bits of sdr_addr as data.
module tb_tc0480scp_rom_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic busy;

  tc0480scp_rom_responder_if #(.SDR_AW(27)) bus ();

  tc0480scp_rom_responder #(
    .SDR_AW   (27),
    .ROM_BASE (27'h100000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .flush   (flush),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // SDRAM model: per-beat ack latency, log of the address of each acked beat
  int          lat_n [4];
  int          m_cnt;
  logic [1:0]  m_beat;
  int          m_nlog;
  logic [26:0] addr_log [64];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.sdr_ack  <= 1'b0;
      bus.sdr_data <= '0;
      m_cnt        <= 0;
      m_beat       <= '0;
      m_nlog       <= 0;
    end else if (bus.sdr_req != bus.sdr_ack) begin
      if (m_cnt + 1 >= lat_n[m_beat]) begin
        bus.sdr_ack          <= ~bus.sdr_ack;
        bus.sdr_data         <= bus.sdr_addr[15:0];
        addr_log[m_nlog % 64] <= bus.sdr_addr;
        m_nlog               <= m_nlog + 1;
        m_beat               <= m_beat + 2'd1;
        m_cnt                <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for rom_ack==rom_req.
  task automatic do_fetch(input logic [20:0] addr, input logic flush_v, input int exp_lat,
                          input logic [63:0] exp_data, input string tag);
    int lat;
    int busy_bad;
    int data_bad;
    logic [63:0] old;
    lat = 0; busy_bad = 0; data_bad = 0;
    @(negedge clk);
    old = bus.rom_data;
    bus.rom_address = addr;
    bus.rom_req = ~bus.rom_req;
    flush = flush_v;
    while (bus.rom_ack != bus.rom_req && lat < 200) begin
      @(posedge clk); #1;
      flush = 1'b0;
      lat++;
      if (bus.rom_ack != bus.rom_req) begin
        if (!busy) busy_bad++;
        if (bus.rom_data !== old) data_bad++;
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, bus.rom_data, exp_data);
    check({tag, "_busy_gaps"}, 64'(busy_bad), 64'd0);
    check({tag, "_data_moved"}, 64'(data_bad), 64'd0);
  endtask

  initial begin
    int n0;
    int lat;
    logic a0;
    logic s0;
    for (int i = 0; i < 4; i++) lat_n[i] = 1;
    bus.rom_address = '0;
    bus.rom_req = 1'b0;

    #12;
    check("rst_ack",  64'(bus.rom_ack), 64'd0);
    check("rst_data", bus.rom_data, 64'd0);
    check("rst_sreq", 64'(bus.sdr_req), 64'd0);
    check("rst_saddr", 64'(bus.sdr_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // basic 4-beat fetch, N=1
    n0 = m_nlog;
    do_fetch(21'h000040, 1'b0, 9, 64'h0046_0044_0042_0040, "f40");
    check("f40_a0", 64'(addr_log[(n0 + 0) % 64]), 64'h100040);
    check("f40_a1", 64'(addr_log[(n0 + 1) % 64]), 64'h100042);
    check("f40_a2", 64'(addr_log[(n0 + 2) % 64]), 64'h100044);
    check("f40_a3", 64'(addr_log[(n0 + 3) % 64]), 64'h100046);
    check("f40_idle", 64'(busy), 64'd0);

    // low address bits masked, base offset added
    n0 = m_nlog;
    do_fetch(21'h1FFFFF, 1'b0, 9, 64'hFFFE_FFFC_FFFA_FFF8, "ftop");
    check("ftop_a0", 64'(addr_log[n0 % 64]), 64'h2FFFF8);
    check("ftop_beats", 64'(m_nlog - n0), 64'd4);

    // slow beat 2
    lat_n[2] = 3;
    do_fetch(21'h000100, 1'b0, 11, 64'h0106_0104_0102_0100, "fslow");
    lat_n[2] = 1;

    // single extra toggle during FETCH -> queued second fetch
    @(negedge clk);
    a0 = bus.rom_ack;
    bus.rom_address = 21'h000040;
    bus.rom_req = ~bus.rom_req;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.rom_address = 21'h000080;
    bus.rom_req = ~bus.rom_req;
    lat = 0;
    while (bus.rom_ack == a0 && lat < 200) begin @(posedge clk); #1; lat++; end
    check("q1_data", bus.rom_data, 64'h0046_0044_0042_0040);
    check("q1_busy", 64'(busy), 64'd0);
    check("q1_pending", 64'(bus.rom_ack != bus.rom_req), 64'd1);
    @(posedge clk); #1;
    check("q2_busy", 64'(busy), 64'd1);
    check("q2_sdr_pend", 64'(bus.sdr_req != bus.sdr_ack), 64'd1);
    check("q2_saddr", 64'(bus.sdr_addr), 64'h100080);
    lat = 0;
    while (bus.rom_ack != bus.rom_req && lat < 200) begin @(posedge clk); #1; lat++; end
    check("q2_lat", 64'(lat), 64'd8);
    check("q2_data", bus.rom_data, 64'h0086_0084_0082_0080);

    // double toggle during FETCH -> no second fetch
    @(negedge clk);
    bus.rom_address = 21'h000200;
    bus.rom_req = ~bus.rom_req;
    repeat (3) @(posedge clk);
    @(negedge clk); bus.rom_req = ~bus.rom_req;
    @(negedge clk); bus.rom_req = ~bus.rom_req;
    lat = 0;
    while (bus.rom_ack != bus.rom_req && lat < 200) begin @(posedge clk); #1; lat++; end
    check("dt_data", bus.rom_data, 64'h0206_0204_0202_0200);
    n0 = m_nlog;
    s0 = bus.sdr_req;
    repeat (5) @(posedge clk); #1;
    check("dt_eq", 64'(bus.rom_ack == bus.rom_req), 64'd1);
    check("dt_busy", 64'(busy), 64'd0);
    check("dt_sreq", 64'(bus.sdr_req), 64'(s0));
    check("dt_beats", 64'(m_nlog - n0), 64'd0);

    // repeat of the last granule
    n0 = m_nlog;
`ifdef ROM_LAST_HIT_EN
    do_fetch(21'h000205, 1'b0, 1, 64'h0206_0204_0202_0200, "hit");
    check("hit_beats", 64'(m_nlog - n0), 64'd0);
`else
    do_fetch(21'h000205, 1'b0, 9, 64'h0206_0204_0202_0200, "rep");
    check("rep_beats", 64'(m_nlog - n0), 64'd4);
`endif
    n0 = m_nlog;
    do_fetch(21'h000200, 1'b1, 9, 64'h0206_0204_0202_0200, "flush");
    check("flush_beats", 64'(m_nlog - n0), 64'd4);

    // reset during beat 1
    @(negedge clk);
    bus.rom_address = 21'h000300;
    bus.rom_req = ~bus.rom_req;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    bus.rom_req = 1'b0;
    #1;
    check("mr_ack",  64'(bus.rom_ack), 64'd0);
    check("mr_data", bus.rom_data, 64'd0);
    check("mr_sreq", 64'(bus.sdr_req), 64'd0);
    check("mr_saddr", 64'(bus.sdr_addr), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk);
    n0 = m_nlog;
    do_fetch(21'h000200, 1'b0, 9, 64'h0206_0204_0202_0200, "post");
    check("post_beats", 64'(m_nlog - n0), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
